// File: rtl/tt_pattern_pkg.sv
// Shared encodings for the test-pattern counter tiles: count modes and default
// Galois LFSR feedback masks (maximal-length) for common widths.
package tt_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/tt_rst_sync.sv
// Reset synchroniser: asserts asynchronously with rst_n, releases on the
// STAGES-th rising clk edge after rst_n rises. No flow control.
module tt_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/tt_pattern_counter.sv
// Prescaled up/down/LFSR/hold pattern counter; count, tick and wrap update one cycle after a step.
// Freezes while ena or run is low (load still honoured with ena); gray output enabled by TT_PATTERN_COUNTER_GRAY_EN.
module tt_pattern_counter
  import tt_pattern_pkg::*;
#(
  parameter int                WIDTH      = 8,
  parameter int                PRESCALE_W = 4,
  parameter logic [WIDTH-1:0]  LFSR_TAPS  = WIDTH'(LFSR_TAPS_8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  wrap,
  output logic [WIDTH-1:0]      gray
);

  logic                  rst_i_n;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  step;
  logic                  do_load;
  logic [WIDTH-1:0]      count_nxt;
  logic                  wrap_nxt;

  tt_rst_sync #(.STAGES(2)) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_i_n)
  );

  assign do_load = ena && load;
  assign step    = ena && run && (pcnt == div);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    case (mode_e'(mode))
      MODE_UP: begin
        count_nxt = count + WIDTH'(1);
        wrap_nxt  = &count;
      end
      MODE_DOWN: begin
        count_nxt = count - WIDTH'(1);
        wrap_nxt  = ~|count;
      end
      MODE_LFSR: begin
        // All-zero is the Galois lock-up state; kick it to 1 without flagging a wrap.
        if (count == '0) begin
          count_nxt = WIDTH'(1);
        end else begin
          count_nxt = (count >> 1) ^ (count[0] ? LFSR_TAPS : '0);
          wrap_nxt  = (count_nxt == WIDTH'(1));
        end
      end
      default: ;
    endcase
  end

  // A shrunken div never forces an early step: pcnt free-runs through all-ones until it matches again.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      pcnt  <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (do_load) begin
        count <= load_val;
        pcnt  <= '0;
      end else if (ena && run) begin
        if (step) begin
          pcnt  <= '0;
          count <= count_nxt;
          tick  <= 1'b1;
          wrap  <= wrap_nxt;
        end else begin
          pcnt <= pcnt + PRESCALE_W'(1);
        end
      end
    end
  end

`ifdef TT_PATTERN_COUNTER_GRAY_EN
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) gray <= '0;
    else          gray <= count ^ (count >> 1);
  end
`else
  assign gray = '0;
`endif

endmodule

// File: tb/tb_tt_pattern_counter.sv
// Self-checking bench for tt_pattern_counter (WIDTH=8, PRESCALE_W=4, taps 8'hB8).
module tb_tt_pattern_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       run = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] div = 4'd0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       tick;
  logic       wrap;
  logic [7:0] gray;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       wrap;
    logic [7:0] gray;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tt_pattern_counter #(.WIDTH(8), .PRESCALE_W(4), .LFSR_TAPS(8'hB8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (run),
    .mode     (mode),
    .div      (div),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap),
    .gray     (gray)
  );

  function automatic logic [7:0] exp_gray(input logic [7:0] prev);
`ifdef TT_PATTERN_COUNTER_GRAY_EN
    return prev ^ (prev >> 1);
`else
    return 8'h00;
`endif
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] ec [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
    logic       et [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] prev = 8'h00;
    rst_n = 1'b0; ena = 1'b1; run = 1'b1; div = 4'd0; mode = 2'b00; load = 1'b0;
    repeat (3) adv();
    checks++;
    if (count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || gray !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold count=%h tick=%b wrap=%b gray=%h required all zero", count, tick, wrap, gray);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({ec[i], et[i], 1'b0, exp_gray(prev)});
      prev = ec[i];
      adv();
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap || gray !== e.gray) begin
        failures++;
        $display("FAIL reset_release cyc=%0d count=%h tick=%b wrap=%b gray=%h required count=%h tick=%b wrap=%b gray=%h",
                 i, count, tick, wrap, gray, e.count, e.tick, e.wrap, e.gray);
      end
    end
  endtask

  task automatic test_prescale_wrap();
    div = 4'd3; mode = 2'b00; run = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      load = (i == 0); load_val = 8'hFE;
      case (i)
        4:       sb.push_back({8'hFF, 1'b1, 1'b0, 8'h00});
        5, 6, 7: sb.push_back({8'hFF, 1'b0, 1'b0, 8'h00});
        8:       sb.push_back({8'h00, 1'b1, 1'b1, 8'h00});
        9,10,11: sb.push_back({8'h00, 1'b0, 1'b0, 8'h00});
        12:      sb.push_back({8'h01, 1'b1, 1'b0, 8'h00});
        default: sb.push_back({8'hFE, 1'b0, 1'b0, 8'h00});
      endcase
      adv();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL prescale_wrap cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_down_lfsr();
    logic [7:0] ec [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    logic       et [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] c, nx;
    logic       w;
    int         dut_wraps = 0;
    div = 4'd0; mode = 2'b01; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load = (i == 0); load_val = 8'h01;
      sb.push_back({ec[i], et[i], ew[i], 8'h00});
      adv();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL down cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
    mode = 2'b10; load = 1'b1; load_val = 8'h00;
    c = 8'h00;
    for (int i = 0; i <= 256; i++) begin
      if (i == 0) begin
        nx = 8'h00; w = 1'b0;
      end else if (c == 8'h00) begin
        nx = 8'h01; w = 1'b0;
      end else begin
        nx = (c >> 1) ^ (c[0] ? 8'hB8 : 8'h00);
        w  = (nx == 8'h01);
      end
      sb.push_back({nx, (i != 0), w, 8'h00});
      adv();
      load = 1'b0;
      c = nx;
      dut_wraps += int'(wrap);
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL lfsr cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
    checks++;
    if (dut_wraps != 1 || count !== 8'h01) begin
      failures++;
      $display("FAIL lfsr_period wraps=%0d count=%h required wraps=1 count=01", dut_wraps, count);
    end
  endtask

  task automatic test_load_vs_step();
    logic       ld [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] lv [11] = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ec [11] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5B};
    div = 4'd3; mode = 2'b00; run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      load = ld[i]; load_val = lv[i];
      sb.push_back({ec[i], (i == 10), 1'b0, 8'h00});
      adv();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL load_vs_step cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_freeze_hold();
    // Starts with pcnt=0, count=5B, div=3: two edges leave pcnt at 2.
    for (int i = 0; i < 34; i++) begin
      ena = !(i >= 2 && i < 12);
      run = !(i >= 12 && i < 22) && i != 24;
      load = (i >= 2 && i < 12) || i == 24;
      load_val = (i == 24) ? 8'h77 : 8'h00;
      mode = (i >= 25) ? 2'b11 : 2'b00;
      div  = (i >= 25) ? 4'd0 : 4'd3;
      if (i == 23)     sb.push_back({8'h5C, 1'b1, 1'b0, 8'h00});
      else if (i >= 24) sb.push_back({8'h77, (i >= 25), 1'b0, 8'h00});
      else             sb.push_back({8'h5B, 1'b0, 1'b0, 8'h00});
      adv();
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL freeze_hold cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
    ena = 1'b1; load = 1'b0;
  endtask

  task automatic test_div_change();
    mode = 2'b00; div = 4'd3; run = 1'b1;
    for (int i = 0; i < 21; i++) begin
      load = (i == 0); load_val = 8'h40;
      if (i == 3) div = 4'd1;
      if (i == 18)      sb.push_back({8'h41, 1'b1, 1'b0, 8'h00});
      else if (i == 20) sb.push_back({8'h42, 1'b1, 1'b0, 8'h00});
      else              sb.push_back({(i > 18) ? 8'h41 : 8'h40, 1'b0, 1'b0, 8'h00});
      adv();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap) begin
        failures++;
        $display("FAIL div_change cyc=%0d count=%h tick=%b wrap=%b required count=%h tick=%b wrap=%b",
                 i, count, tick, wrap, e.count, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] ec [6] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] prev = 8'h00;
    mode = 2'b00; div = 4'd0; run = 1'b1; load = 1'b1; load_val = 8'h36;
    adv();
    load = 1'b0;
    adv();
    checks++;
    if (count !== 8'h37 || tick !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset count=%h tick=%b required count=37 tick=1", count, tick);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || gray !== 8'h00) begin
      failures++;
      $display("FAIL async_clear count=%h tick=%b wrap=%b gray=%h required all zero", count, tick, wrap, gray);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({ec[i], (i >= 2), 1'b0, exp_gray(prev)});
      prev = ec[i];
      adv();
      e = sb.pop_front();
      checks++;
      if (count !== e.count || tick !== e.tick || wrap !== e.wrap || gray !== e.gray) begin
        failures++;
        $display("FAIL async_resume cyc=%0d count=%h tick=%b wrap=%b gray=%h required count=%h tick=%b wrap=%b gray=%h",
                 i, count, tick, wrap, gray, e.count, e.tick, e.wrap, e.gray);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescale_wrap();
    test_down_lfsr();
    test_load_vs_step();
    test_freeze_hold();
    test_div_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_pattern_counter.md
Name: tt_pattern_counter

Overview:
- Parametrised test-pattern counter for TinyTapeout bring-up tiles; successor to the fixed 8-bit free-running test counter.
- Adds width generalisation, a programmable prescaler, selectable count modes (up, down, LFSR, hold), synchronous load and a wrap flag.
- Sits behind the tile top, which muxes its outputs onto uo_out/uio_out.
- Includes an internal reset synchroniser so the tile reset pin can be asserted asynchronously without metastable release.

Parameters:
- WIDTH, 8, counter/pattern width in bits (2..32).
- PRESCALE_W, 4, width of the prescaler divide register.
- LFSR_TAPS, 8'hB8, Galois feedback mask for LFSR mode; must be WIDTH bits wide (maximal-length for WIDTH=8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  tile enable; when 0, the prescaler and counter freeze.
- run  in  1  count enable; when 0, the prescaler and counter freeze; load still works.
- mode  in  2  00 up, 01 down, 10 LFSR, 11 hold.
- div  in  PRESCALE_W  prescale: one count step every div+1 cycles.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded on load.
- count  out  WIDTH  current pattern value.
- tick  out  1  single-cycle pulse in each cycle a count step is applied.
- wrap  out  1  single-cycle pulse when a step wraps, as defined below.
- gray  out  WIDTH  Gray-coded count (optional feature; see below).

Behaviour:
- Reset sync:
  - rst_n low asynchronously clears the 2-flop synchroniser, the prescaler, count, tick, wrap and gray to 0.
  - Internal reset rst_i releases on the 2nd rising clk edge after rst_n rises.
  - All state except the synchroniser resets on rst_i.
- Prescaler:
  - pcnt counts 0..div while ena&&run.
  - step = ena && run && (pcnt==div); pcnt returns to 0 on step.
  - div=0 gives a step every cycle.
  - If div is changed below the current pcnt, pcnt keeps counting to all-ones, wraps to 0, then compares again. No early step.
- Count update on step (registered, visible the cycle after step):
  - up: count+1, modulo 2^WIDTH; wrap when count was all-ones.
  - down: count-1; wrap when count was 0.
  - LFSR: Galois right shift, next = (count>>1) ^ (count[0] ? LFSR_TAPS : 0). Lock-up guard: count==0 gives next=1 and no wrap. wrap when next==1.
  - hold: count unchanged; tick still pulses; wrap=0.
- tick and wrap:
  - Both are registered and coincident with the updated count value.
  - Both are 0 in all other cycles.
- load:
  - load has priority over step in the same cycle: count<=load_val and pcnt<=0.
  - tick and wrap are 0 in the load cycle.
  - load is honoured regardless of run; it is ignored when ena=0.
- mode changes take effect at the next step; no state is flushed.
- Reset mid-operation: immediate async clear; counting resumes from 0 with pcnt=0 after the 2-cycle release.

Optional Feature:
- Macro: TT_PATTERN_COUNTER_GRAY_EN.
- Defined: gray is registered as count ^ (count>>1), computed from the already-registered count. It therefore lags count by one cycle and resets to 0.
- Undefined: gray is tied to 0 and no gray flops are synthesised.

Decomposition:
- Package tt_pattern_pkg:
  - mode encodings as a 2-bit enum: MODE_UP, MODE_DOWN, MODE_LFSR, MODE_HOLD.
  - default LFSR tap constants for widths 4, 8, 16 and 32.
- Sub-module tt_rst_sync: 2-flop asynchronous-assert / synchronous-release reset synchroniser with a STAGES parameter, default 2. It is reused by other tiles.

Test Plan:
- Reset release: hold rst_n=0, then release with run=1, div=0, mode=up. Required: count stays 0 for 2 edges, then reads 1, 2, 3 on successive cycles; tick high each step.
- Prescale and wrap: div=3, mode=up, load 8'hFE. Required: steps every 4 cycles; count goes FE→FF→00; wrap high for exactly one cycle at 00; tick every 4th cycle.
- Down and LFSR:
  - Down: load 8'h01, mode=down, div=0 gives 00 then FF, with wrap at FF.
  - LFSR: load 0, mode=LFSR gives count 1 after the first step. Period is 255 steps, and wrap pulses once per period.
- Load versus step: load=1 with load_val=8'h5A in the same cycle as a step. Required: count=5A, tick=0, wrap=0, pcnt restarts from 0.
- Freeze and hold:
  - ena=0 or run=0 for 10 cycles: count and pcnt are unchanged.
  - mode=hold with run=1, div=0: tick pulses every cycle while count stays constant.
- Async reset mid-count (GRAY_EN defined): pulse rst_n low mid-cycle at count=8'h37. Required: count, tick, wrap and gray read 0 immediately. After release, gray follows the count sequence 1, 2, 3 as 01, 03, 02, lagging count by one cycle.
